// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encodings, oversampling ratio and a width helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_START  = 5'b00010;
    localparam logic [4:0] ST_DATA   = 5'b00100;
    localparam logic [4:0] ST_PARITY = 5'b01000;
    localparam logic [4:0] ST_STOP   = 5'b10000;

    // Number of bits needed to hold the value itself: clogb2(15) = 4, clogb2(31) = 5.
    function automatic int clogb2(input int value);
        int n;
        n = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional parity, stop period,
// all timed from the shared 16x oversampling tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int SB_TICKS   = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_txstart,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_txdone,
    output logic               o_busy
);

    localparam int NB_TICK = clogb2(SB_TICKS - 1);
    localparam int NB_BIT  = (NB_DATA > 1) ? clogb2(NB_DATA - 1) : 1;

    localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(OVERSAMPLE - 1);
    localparam logic [NB_TICK-1:0] STOP_LAST = NB_TICK'(SB_TICKS - 1);
    localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_DATA - 1);
    localparam logic               ODD_BIT   = (PARITY_ODD != 0);
    localparam logic [4:0]         AFTER_DATA = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;

    logic [4:0]         state, state_next;
    logic [NB_TICK-1:0] tick_cnt, tick_next;
    logic [NB_BIT-1:0]  bit_cnt, bit_next;
    logic [NB_DATA-1:0] shreg, shreg_next;
    logic               parity, parity_next;
    logic               done_next;
    logic               tx_next;

    always_comb begin
        state_next  = state;
        tick_next   = tick_cnt;
        bit_next    = bit_cnt;
        shreg_next  = shreg;
        parity_next = parity;
        done_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                // A tick in the accepting cycle is deliberately not counted.
                if (i_txstart) begin
                    shreg_next  = i_data;
                    parity_next = (^i_data) ^ ODD_BIT;
                    tick_next   = '0;
                    state_next  = ST_START;
                end
            end

            ST_START: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = ST_DATA;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        shreg_next = shreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            state_next = AFTER_DATA;
                        end else begin
                            bit_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        state_next = ST_STOP;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (i_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_next  = '0;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end

            default: begin
                tick_next  = '0;
                bit_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so o_tx can come straight from a flop.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg_next[0];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
            o_tx     <= 1'b1;
            o_txdone <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            parity   <= parity_next;
            o_tx     <= tx_next;
            o_txdone <= done_next;
            o_busy   <= (state_next != ST_IDLE);
        end
    end

    a_state_onehot: assert property (@(posedge clk) disable iff (!i_rst_n) $onehot(state));
    a_done_not_busy: assert property (@(posedge clk) disable iff (!i_rst_n) o_txdone |-> !o_busy);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven in lockstep and checked every cycle
// against a tick-count frame model, plus directed timing and corner sequences.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick;
    logic       tick_en;
    logic       txstart;
    logic [7:0] data;
    logic [3:0] tx, done, busy;

    always #5 clk = ~clk;

    // inst0: 8N1, inst1: even parity, inst2: odd parity + 1.5 stop, inst3: 2 stop bits
    int cfg_pen [4] = '{0, 1, 1, 0};
    int cfg_odd [4] = '{0, 0, 1, 0};
    int cfg_sbt [4] = '{16, 16, 24, 32};

    uart_tx #(.NB_DATA(8), .SB_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_txstart(txstart), .i_data(data),
        .o_tx(tx[0]), .o_txdone(done[0]), .o_busy(busy[0]));
    uart_tx #(.NB_DATA(8), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_txstart(txstart), .i_data(data),
        .o_tx(tx[1]), .o_txdone(done[1]), .o_busy(busy[1]));
    uart_tx #(.NB_DATA(8), .SB_TICKS(24), .PARITY_EN(1), .PARITY_ODD(1)) u_8o15 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_txstart(txstart), .i_data(data),
        .o_tx(tx[2]), .o_txdone(done[2]), .o_busy(busy[2]));
    uart_tx #(.NB_DATA(8), .SB_TICKS(32), .PARITY_EN(0), .PARITY_ODD(0)) u_8n2 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_txstart(txstart), .i_data(data),
        .o_tx(tx[3]), .o_txdone(done[3]), .o_busy(busy[3]));

    // Tick strobe every 4 clk, gated by tick_en.
    int tdiv;
    initial begin
        tdiv = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tdiv = (tdiv + 1) % 4;
            tick = tick_en && (tdiv == 0);
        end
    end

    // Reference model: a frame is just a count of ticks since acceptance.
    logic       m_busy [4];
    logic       m_done [4];
    int         m_e    [4];
    logic [7:0] m_word [4];
    int         tick_total = 0;

    function automatic int frame_ticks(input int i);
        return 16 * (1 + 8 + cfg_pen[i]) + cfg_sbt[i];
    endfunction

    function automatic logic exp_line(input int i);
        int b;
        if (!m_busy[i]) return 1'b1;
        b = m_e[i] / 16;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_word[i][b-1];
        if (cfg_pen[i] != 0 && b == 9) return (^m_word[i]) ^ cfg_odd[i][0];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_e[i]    <= 0;
                m_word[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (tick) begin
                        m_e[i] <= m_e[i] + 1;
                        if (m_e[i] + 1 == frame_ticks(i)) begin
                            m_busy[i] <= 1'b0;
                            m_done[i] <= 1'b1;
                        end
                    end
                end else if (txstart) begin
                    m_busy[i] <= 1'b1;
                    m_e[i]    <= 0;
                    m_word[i] <= data;
                end
            end
        end
    end

    always @(posedge clk) tick_total <= tick_total + int'(tick);

    // Per-cycle comparison of {tx, busy, done}; mismatches are tallied per instance.
    int         cyc_err  [4] = '{0, 0, 0, 0};
    int         done_cnt [4] = '{0, 0, 0, 0};
    logic [2:0] last_act [4];
    logic [2:0] last_exp [4];
    time        last_t   [4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if ({tx[i], busy[i], done[i]} !== {exp_line(i), m_busy[i], m_done[i]}) begin
                cyc_err[i]  <= cyc_err[i] + 1;
                last_act[i] <= {tx[i], busy[i], done[i]};
                last_exp[i] <= {exp_line(i), m_busy[i], m_done[i]};
                last_t[i]   <= $time;
            end
            done_cnt[i] <= done_cnt[i] + int'(done[i] === 1'b1);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int err_base  [4] = '{0, 0, 0, 0};
    int done_base [4] = '{0, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting, got no event expected one", name);
    endtask

    task automatic check_window(input string name);
        int e;
        #1;
        for (int i = 0; i < 4; i++) begin
            e = cyc_err[i] - err_base[i];
            n_cmp++;
            if (e != 0) begin
                n_bad++;
                $display("FAIL %s inst%0d: %0d bad cycles, last t=%0t got tx/busy/done=%b expected %b",
                         name, i, e, last_t[i], last_act[i], last_exp[i]);
            end
            err_base[i] = cyc_err[i];
        end
    endtask

    task automatic mark_done();
        for (int i = 0; i < 4; i++) done_base[i] = done_cnt[i];
    endtask

    task automatic chk_done_delta(input string name, input int exp);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_inst%0d", name, i), done_cnt[i] - done_base[i], exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        data    = d;
        txstart = 1'b1;
        @(negedge clk);
        txstart = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((m_busy[0] || m_busy[1] || m_busy[2] || m_busy[3]) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) timeout_fail(name);
    endtask

    task automatic wait_e(input int i, input int target, input string name);
        int n;
        n = 0;
        while (!(m_busy[i] && m_e[i] >= target) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) timeout_fail(name);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
    } vec_t;

    vec_t vt [6];

    initial begin
        automatic int   k, h, n, t0;
        automatic int   len [4];
        automatic logic [3:0] got;
        automatic logic [3:0] snap_tx, snap_busy;
        automatic logic changed, seen;
        automatic int   exp_len [4] = '{160, 176, 184, 176};

        vt[0] = '{8'h07, 1'b1, 1'b0};
        vt[1] = '{8'h03, 1'b0, 1'b1};
        vt[2] = '{8'h55, 1'b0, 1'b1};
        vt[3] = '{8'hA3, 1'b0, 1'b1};
        vt[4] = '{8'h80, 1'b1, 1'b0};
        vt[5] = '{8'hFE, 1'b1, 1'b0};

        txstart = 1'b0;
        data    = 8'h00;
        tick_en = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_tx_inst%0d", i), tx[i], 1'b1);
            chk($sformatf("reset_busy_inst%0d", i), busy[i], 1'b0);
            chk($sformatf("reset_done_inst%0d", i), done[i], 1'b0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_window("idle_after_reset");

        // Parity table across even/odd instances
        for (int v = 0; v < 6; v++) begin
            send(vt[v].data);
            wait_e(1, 152, "parity_wait");
            chk($sformatf("par_even_%02h", vt[v].data), tx[1], vt[v].par_even);
            chk($sformatf("par_odd_%02h", vt[v].data), tx[2], vt[v].par_odd);
            wait_idle("table_idle");
            check_window($sformatf("table_%02h", vt[v].data));
        end

        // 0x55 8N1: start bit length and a full data bit length
        mark_done();
        send(8'h55);
        k = 0;
        while (tx[0] == 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k < 60 || k > 64) begin
            n_bad++;
            $display("FAIL start_bit_len: got %0d clk expected 60..64", k);
        end
        h = 0;
        while (tx[0] == 1'b1 && h < 200) begin
            @(negedge clk);
            h++;
        end
        chk("data_bit0_len", h, 64);
        wait_idle("x55_idle");
        check_window("x55_frame");
        chk_done_delta("x55_done_count", 1);

        // Frame length in ticks for every configuration (0xA3)
        @(negedge clk);
        data    = 8'hA3;
        txstart = 1'b1;
        @(negedge clk);
        txstart = 1'b0;
        t0  = tick_total;
        got = 4'b0000;
        n   = 0;
        for (int i = 0; i < 4; i++) len[i] = -1;
        while (got != 4'hF && n < 3000) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) begin
                if (done[i] && !got[i]) begin
                    got[i] = 1'b1;
                    len[i] = tick_total - t0;
                end
            end
        end
        for (int i = 0; i < 4; i++) chk($sformatf("frame_ticks_inst%0d", i), len[i], exp_len[i]);
        wait_idle("len_idle");
        check_window("frame_len");

        // Request while busy is ignored
        mark_done();
        send(8'h12);
        wait_e(0, 50, "busy_req_wait");
        data    = 8'hFF;
        txstart = 1'b1;
        @(negedge clk);
        txstart = 1'b0;
        data    = 8'h00;
        wait_idle("busy_req_idle");
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 4'b0000) seen = 1'b1;
        end
        chk("no_second_frame", seen, 1'b0);
        check_window("busy_req");
        chk_done_delta("busy_req_done_count", 1);

        // Request held through txdone starts the next frame one clk later
        mark_done();
        send(8'h56);
        wait_e(0, 100, "b2b_wait");
        data    = 8'h34;
        txstart = 1'b1;
        n = 0;
        while (done[0] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout_fail("b2b_done0");
        chk("b2b_done_tx", tx[0], 1'b1);
        chk("b2b_done_busy", busy[0], 1'b0);
        @(negedge clk);
        chk("b2b_restart_tx", tx[0], 1'b0);
        chk("b2b_restart_busy", busy[0], 1'b1);
        chk("b2b_restart_done", done[0], 1'b0);
        n = 0;
        while (done[2] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout_fail("b2b_done2");
        @(negedge clk);
        txstart = 1'b0;
        wait_idle("b2b_idle");
        check_window("b2b");
        chk_done_delta("b2b_done_count", 2);

        // Tick stall during DATA
        send(8'h5A);
        wait_e(0, 16 * 3 + 2, "stall_wait");
        tick_en = 1'b0;
        repeat (3) @(negedge clk);
        snap_tx   = tx;
        snap_busy = busy;
        changed   = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== snap_tx || busy !== snap_busy) changed = 1'b1;
        end
        chk("stall_frozen", changed, 1'b0);
        tick_en = 1'b1;
        wait_idle("stall_idle");
        check_window("stall");

        // Asynchronous reset in the middle of data bit 3
        send(8'hF0);
        wait_e(0, 16 * 4 + 8, "rst_wait");
        #1;
        mark_done();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_rst_tx_inst%0d", i), tx[i], 1'b1);
            chk($sformatf("async_rst_busy_inst%0d", i), busy[i], 1'b0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        chk_done_delta("rst_no_done", 0);
        check_window("rst_abort");
        mark_done();
        send(8'hC3);
        wait_idle("rst_after_idle");
        check_window("rst_after_frame");
        chk_done_delta("rst_after_done", 1);

        // Randomized frames with spurious mid-frame requests and random tick phase
        for (int r = 0; r < 12; r++) begin
            send(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(10, 600)) @(negedge clk);
                data    = 8'($urandom);
                txstart = 1'b1;
                @(negedge clk);
                txstart = 1'b0;
            end
            wait_idle("rand_idle");
            repeat ($urandom_range(0, 9)) @(negedge clk);
            check_window($sformatf("rand_%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 900000 ns");
        $fatal(1);
    end

endmodule
